ram_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters, A and B.
- The RAM registers its address on clk and presents read data after the edge.
- Per-cycle round-robin arbitration with a bounded burst hold; read data is returned to the winning port one cycle after grant.
- Sits directly in front of the RAM; requesters never drive the RAM themselves.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arbiter_rr_pick2.sv | 35 +++
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Owner state encoding, port indices and stats counter width.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  localparam int PORT_A  = 0;
  localparam int PORT_B  = 1;
  localparam int STAT_W  = 16;
  localparam int BURST_W = 4;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick with burst hold.
// Returns a one-hot grant indexed by PORT_A / PORT_B.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic               req_a,
  input  logic               req_b,
  input  owner_e             owner,
  input  logic [BURST_W-1:0] burst_cnt,
  input  logic               last_winner,
  input  logic [BURST_W-1:0] max_burst,
  output logic [1:0]         gnt
);

  logic win_a;

  // Decide the contested winner, then apply it only when both request
  always_comb begin
    win_a = 1'b0;
    gnt   = '0;
    unique case (owner)
      OWN_A:   win_a = (burst_cnt < max_burst);
      OWN_B:   win_a = !(burst_cnt < max_burst);
      default: win_a = last_winner;
    endcase
    if (req_a && req_b) begin
      gnt[PORT_A] = win_a;
      gnt[PORT_B] = !win_a;
    end else begin
      gnt[PORT_A] = req_a;
      gnt[PORT_B] = req_b;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Optional grant/contention counters when RAM_ARB_STATS_EN is defined.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8,
  parameter int max_burst  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [addr_width-1:0] a_addr,
  input  logic [data_width-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [data_width-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [addr_width-1:0] b_addr,
  input  logic [data_width-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [data_width-1:0] b_rdata,
`ifdef RAM_ARB_STATS_EN
  output logic [STAT_W-1:0]     a_grant_cnt,
  output logic [STAT_W-1:0]     b_grant_cnt,
  output logic [STAT_W-1:0]     contention_cnt,
`endif
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(max_burst);

  owner_e                owner_q, owner_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic                  last_q, last_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  a_rv_q, a_rv_d;
  logic                  b_rv_q, b_rv_d;
  logic [1:0]            pick;

  rr_pick2 u_pick (
    .req_a       (a_req),
    .req_b       (b_req),
    .owner       (owner_q),
    .burst_cnt   (burst_q),
    .last_winner (last_q),
    .max_burst   (MAX_B),
    .gnt         (pick)
  );

  assign a_gnt    = pick[PORT_A] & ~rst;
  assign b_gnt    = pick[PORT_B] & ~rst;
  assign a_rvalid = a_rv_q;
  assign b_rvalid = b_rv_q;
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

  // RAM mux from the granted port; idle holds address, zeroes data
  always_comb begin
    ram_we  = 1'b0;
    ram_din = '0;
    addr_d  = addr_q;
    if (a_gnt) begin
      ram_we  = a_we;
      ram_din = a_wdata;
      addr_d  = a_addr;
    end else if (b_gnt) begin
      ram_we  = b_we;
      ram_din = b_wdata;
      addr_d  = b_addr;
    end
    ram_addr = addr_d;
  end

  // Next owner, burst count, last winner and read-valid pipeline
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    last_d  = last_q;
    a_rv_d  = a_gnt & ~a_we;
    b_rv_d  = b_gnt & ~b_we;
    if (a_gnt) begin
      last_d = 1'b0;
      if (owner_q == OWN_A) begin
        burst_d = (burst_q >= MAX_B) ? MAX_B : burst_q + 1'b1;
      end else begin
        owner_d = OWN_A;
        burst_d = BURST_W'(1);
      end
    end else if (b_gnt) begin
      last_d = 1'b1;
      if (owner_q == OWN_B) begin
        burst_d = (burst_q >= MAX_B) ? MAX_B : burst_q + 1'b1;
      end else begin
        owner_d = OWN_B;
        burst_d = BURST_W'(1);
      end
    end else begin
      owner_d = NONE;
      burst_d = '0;
    end
  end

  // Arbitration state and read-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= NONE;
      burst_q <= '0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [STAT_W-1:0] a_cnt_q, a_cnt_d;
  logic [STAT_W-1:0] b_cnt_q, b_cnt_d;
  logic [STAT_W-1:0] c_cnt_q, c_cnt_d;

  assign a_grant_cnt    = a_cnt_q;
  assign b_grant_cnt    = b_cnt_q;
  assign contention_cnt = c_cnt_q;

  // Saturating grant and contention counters
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    c_cnt_d = c_cnt_q;
    if (a_gnt && a_cnt_q != '1) a_cnt_d = a_cnt_q + 1'b1;
    if (b_gnt && b_cnt_q != '1) b_cnt_d = b_cnt_q + 1'b1;
    if (a_req && b_req && c_cnt_q != '1) c_cnt_d = c_cnt_q + 1'b1;
  end

  // Stats registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      c_cnt_q <= c_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and
// a rule-level reference model of arbitration and read return.
module tb_ram_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we;
  logic [7:0] ram_addr, ram_din, ram_dout;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] a_grant_cnt, b_grant_cnt, contention_cnt;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.addr_width(8), .data_width(8), .max_burst(MB)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef RAM_ARB_STATS_EN
    .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
    .contention_cnt(contention_cnt),
`endif
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Single-port synchronous RAM: address registered on the edge
  logic [7:0] mem [256];
  logic [7:0] raddr;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    raddr <= ram_addr;
  end
  assign ram_dout = mem[raddr];

  int total = 0;
  int bad = 0;

  // Reference model state
  int         m_own;
  int         m_run;
  int         m_last;
  logic [7:0] m_addr;
  logic [7:0] ref_mem [256];
  bit         ref_ok [256];
  logic       exp_av, exp_bv;
  logic [7:0] exp_ad, exp_bd;
  bit         exp_ad_ok, exp_bd_ok;
  logic       last_ga, last_gb;
  int         s_a, s_b, s_c;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_run  = 0;
    m_last = 1;
    m_addr = 8'h00;
    exp_av = 1'b0;
    exp_bv = 1'b0;
    s_a = 0;
    s_b = 0;
    s_c = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: check returned reads, drive, check grant and RAM mux
  task automatic step(input logic ar, input logic aw,
                      input logic [7:0] aa, input logic [7:0] ad,
                      input logic br, input logic bw,
                      input logic [7:0] ba, input logic [7:0] bd);
    logic ga, gb;
    logic e_we;
    logic [7:0] e_addr, e_din;
    @(negedge clk);
    chk("a_rvalid", a_rvalid, exp_av);
    chk("b_rvalid", b_rvalid, exp_bv);
    if (exp_av && exp_ad_ok) chk("a_rdata", a_rdata, exp_ad);
    if (exp_bv && exp_bd_ok) chk("b_rdata", b_rdata, exp_bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    if (ar && br) begin
      if (m_own == 0)      ga = (m_run < MB);
      else if (m_own == 1) ga = (m_run >= MB);
      else                 ga = (m_last == 1);
      gb = !ga;
    end else begin
      ga = ar;
      gb = br;
    end
    e_we   = ga ? aw : (gb ? bw : 1'b0);
    e_addr = ga ? aa : (gb ? ba : m_addr);
    e_din  = ga ? ad : (gb ? bd : 8'h00);
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_din", ram_din, e_din);
    exp_av = ga && !aw;
    exp_bv = gb && !bw;
    exp_ad = ref_mem[aa];
    exp_bd = ref_mem[ba];
    exp_ad_ok = ref_ok[aa];
    exp_bd_ok = ref_ok[ba];
    if (ga || gb) begin
      if (m_own == (ga ? 0 : 1)) m_run = (m_run < MB) ? m_run + 1 : MB;
      else begin
        m_own = ga ? 0 : 1;
        m_run = 1;
      end
      m_last = ga ? 0 : 1;
      m_addr = e_addr;
      if (e_we) begin
        ref_mem[e_addr] = e_din;
        ref_ok[e_addr]  = 1'b1;
      end
    end else begin
      m_own = -1;
      m_run = 0;
    end
    if (ga && s_a < 65535) s_a++;
    if (gb && s_b < 65535) s_b++;
    if (ar && br && s_c < 65535) s_c++;
    last_ga = ga;
    last_gb = gb;
  endtask

  initial begin
    logic [8:0] pat;
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    for (int i = 0; i < 256; i++) ref_ok[i] = 1'b0;
    model_reset();

    // Grant and write suppressed while reset is held
    @(negedge clk);
    #1;
    chk("rst_a_gnt", a_gnt, 1'b0);
    chk("rst_b_gnt", b_gnt, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Idle three cycles, first request at cycle 3
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    step(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00);
    chk("c3_a_gnt", last_ga, 1'b1);
    step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    chk("rb_rdata_5a", a_rdata, 8'h5A);
    chk("rb_b_rvalid", b_rvalid, 1'b0);

    // Both requesting continuously from reset
    do_reset();
    pat = 9'b100001111;
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 8'(i), 8'h00, 1, 0, 8'(i + 1), 8'h00);
      chk("rr_pattern", last_ga, pat[i]);
    end

    // B streams 20 reads alone, then A must win immediately
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8'h00, 8'h00, 1, 0, 8'(i & 15), 8'h00);
      chk("b_stream", last_gb, 1'b1);
    end
    step(1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00);
    chk("a_after_stream", last_ga, 1'b1);

    // Asynchronous reset with a read return pending
    step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    @(posedge clk);
    #2;
    chk("pend_rvalid", a_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rvalid", a_rvalid, 1'b0);
    chk("async_gnt", a_gnt, 1'b0);
    @(negedge clk);
    a_req = 1'b0;
    rst = 1'b0;
    model_reset();
    step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    chk("post_rst_a", last_ga, 1'b1);

    // Randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 8'($urandom_range(15)), 8'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom_range(15)), 8'($urandom));
    end
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

`ifdef RAM_ARB_STATS_EN
    chk("a_grant_cnt", a_grant_cnt, 32'(s_a));
    chk("b_grant_cnt", b_grant_cnt, 32'(s_b));
    chk("contention_cnt", contention_cnt, 32'(s_c));
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 8'h20, 8'h11, 0, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00, 1, 1, 8'h21, 8'h22);
    step(1, 1, 8'h22, 8'h33, 1, 1, 8'h23, 8'h44);
    step(1, 1, 8'h24, 8'h55, 1, 1, 8'h25, 8'h66);
    step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    chk("st_a", a_grant_cnt, 32'(s_a));
    chk("st_b", b_grant_cnt, 32'(s_b));
    chk("st_c", contention_cnt, 32'd2);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 8'h77;
    b_req = 1'b0;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    chk("a_cnt_sat", a_grant_cnt, 32'hFFFF);
    ref_mem[8'h30] = 8'h77;
    ref_ok[8'h30]  = 1'b1;
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
